// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// State encoding, ALU opcodes and PSW bit positions.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  localparam int PSW_Z = 0;
  localparam int PSW_C = 1;
  localparam int PSW_S = 2;
  localparam int PSW_X = 3;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or
// after the pointer, wrapping, as one-hot plus index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  int              p;
  logic [ID_W-1:0] pi;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    p     = 0;
    pi    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      p = int'(ptr_i) + k;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      pi = p[ID_W-1:0];
      if (req_i[pi]) begin
        gnt_o     = '0;
        gnt_o[pi] = 1'b1;
        idx_o     = pi;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one 8-bit ALU between requesters.
// Define ALU_ARB_LOCK_EN to add req_lock bounded grant holding.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2
`ifdef ALU_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ*3-1:0] req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_lock,
`endif
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_sel,
  input  logic [7:0]           alu_result,
  input  logic [3:0]           alu_psw,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic [3:0]           rsp_psw
);

  arb_state_t         state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic [2:0]         op_q;
  logic [7:0]         res_q;
  logic [3:0]         psw_q;
  logic               rsp_valid_q;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    rr_idx;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    ptr_d;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(rr_gnt),
    .idx_o(rr_idx)
  );

`ifdef ALU_ARB_LOCK_EN
  logic lock_q;
  logic hold;
  logic lock_keep;
  int   lock_cnt_q;
  int   lock_cnt_d;

  // The last accepted requester keeps the grant while it holds lock.
  assign hold       = lock_q && req_valid[id_q];
  assign lock_cnt_d = hold ? lock_cnt_q + 1 : 0;
  assign lock_keep  = req_lock[gnt_idx] &&
                      (lock_cnt_d < LOCK_MAX - 1);
  assign gnt_idx    = hold ? id_q : rr_idx;
  assign gnt        = hold ? NUM_REQ'(1) << id_q : rr_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_cnt_q <= 0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        lock_q     <= lock_keep;
        lock_cnt_q <= lock_keep ? lock_cnt_d : 0;
      end else if (lock_q && !req_valid[id_q]) begin
        lock_q     <= 1'b0;
        lock_cnt_q <= 0;
      end
    end
  end
`else
  assign gnt_idx = rr_idx;
  assign gnt     = rr_gnt;
`endif

  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign accept    = |req_ready;
  assign ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ?
                     '0 : gnt_idx + ID_W'(1);

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_psw    = psw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      psw_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= req_a[8*gnt_idx +: 8];
            b_q     <= req_b[8*gnt_idx +: 8];
            op_q    <= req_op[3*gnt_idx +: 3];
            id_q    <= gnt_idx;
            ptr_q   <= ptr_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= alu_result;
          psw_q       <= alu_psw;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: bench-side ALU, cycle model, directed ops.
// Set ALU_ARB_LOCK_EN to also exercise grant locking.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N    = 4;
  localparam int LMAX = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic [N*3-1:0] req_op = '0;
  logic [N-1:0]   req_lock = '0;
  logic [7:0]     alu_a, alu_b, alu_result;
  logic [2:0]     alu_sel;
  logic [3:0]     alu_psw;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_result;
  logic [3:0]     rsp_psw;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int ord[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(
    .NUM_REQ(N),
    .ID_W   (2)
`ifdef ALU_ARB_LOCK_EN
    ,
    .LOCK_MAX(LMAX)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .alu_psw   (alu_psw),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_psw   (rsp_psw)
  );

  // Reference ALU: returns {X S C Z, result}
  function automatic logic [11:0] alu_fn(logic [7:0] a, logic [7:0] b,
                                         logic [2:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, x;
    w = '0; r = '0; c = 1'b0; x = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[7:0]; c = w[8];
        x = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        r = a - b; c = (a < b);
        x = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_NOT: r = ~a;
      OP_SHL: begin r = {a[6:0], 1'b0}; c = a[7]; end
      OP_SHR: begin r = {1'b0, a[7:1]}; c = a[0]; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: r = a ^ b;
    endcase
    return {x, r[7], c, (r == 8'd0), r};
  endfunction

  assign {alu_psw, alu_result} = alu_fn(alu_a, alu_b, alu_sel);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Cycle model: one op in flight, response two cycles after accept.
  bit         m_busy = 0, m_rspv = 0, ml = 0;
  int         m_ptr = 0, mg = -1, mp = 0, m_own = -1, m_streak = 0;
  logic [1:0] m_id = '0;
  logic [7:0] m_res = '0;
  logic [3:0] m_psw = '0;
  logic [N-1:0] m_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
      check("rst_rsp", {rsp_id, rsp_psw, rsp_result}, 0);
      m_busy = 0; m_rspv = 0; m_ptr = 0; m_own = -1; m_streak = 0;
    end else begin
      m_rdy = '0; mg = -1; ml = 0;
      if (!m_busy) begin
`ifdef ALU_ARB_LOCK_EN
        if (m_own >= 0) begin
          if (req_valid[m_own]) begin ml = 1; mg = m_own; end
          else begin m_own = -1; m_streak = 0; end
        end
`endif
        for (int k = 0; k < N; k++) begin
          mp = (m_ptr + k) % N;
          if (mg < 0 && req_valid[mp]) mg = mp;
        end
        if (mg >= 0) m_rdy[mg] = 1'b1;
      end
      check("req_ready", req_ready, m_rdy);
      check("rsp_valid", rsp_valid, m_rspv);
      if (m_rspv)
        check("rsp_fields", {rsp_id, rsp_psw, rsp_result},
              {m_id, m_psw, m_res});
      if (m_rspv) begin
        if (rsp_ready) begin m_rspv = 0; m_busy = 0; end
      end else if (m_busy) begin
        m_rspv = 1;
      end else if (mg >= 0) begin
        m_busy = 1;
        m_id = 2'(mg);
        {m_psw, m_res} = alu_fn(req_a[8*mg +: 8], req_b[8*mg +: 8],
                                req_op[3*mg +: 3]);
        m_ptr = (mg + 1) % N;
`ifdef ALU_ARB_LOCK_EN
        if (req_lock[mg]) begin
          m_streak = ml ? m_streak + 1 : 1;
          if (m_streak < LMAX) m_own = mg;
          else begin m_own = -1; m_streak = 0; end
        end else begin
          m_own = -1; m_streak = 0;
        end
`endif
      end
    end
  end

  task automatic drive(input int i, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_op[3*i +: 3] = op;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
    end
    check("grant_wait", ok, 1);
  endtask

  task automatic wait_rsp();
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    check("rsp_wait", ok, 1);
  endtask

  task automatic run_op(input int i, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op,
                        output logic [1:0] id, output logic [7:0] res,
                        output logic [3:0] psw, output int lat);
    int t0;
    @(posedge clk); #1;
    drive(i, a, b, op);
    wait_ready(i);
    t0 = cyc;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    wait_rsp();
    lat = cyc - t0;
    id = rsp_id; res = rsp_result; psw = rsp_psw;
  endtask

  task automatic collect(input int n);
    int got = 0;
    for (int k = 0; k < 60 && got < n; k++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++)
        if (req_ready[j] && got < n) begin ord[got] = j; got++; end
    end
    check("collect_wait", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] id;
    logic [7:0] res;
    logic [3:0] psw;
    int         lat;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op(0, 8'd127, 8'd128, OP_ADD, id, res, psw, lat);
    check("t1_latency", lat, 2);
    check("t1_id", id, 0);
    check("t1_result", res, 255);
    check("t1_psw_cz", psw[1:0], 2'b00);

    run_op(2, 8'd5, 8'd5, OP_SUB, id, res, psw, lat);
    check("t2_sub_id", id, 2);
    check("t2_sub_result", res, 0);
    check("t2_sub_psw", psw, 4'b0001);
    run_op(1, 8'd128, 8'd128, OP_ADD, id, res, psw, lat);
    check("t2_add_id", id, 1);
    check("t2_add_result", res, 0);
    check("t2_add_psw_cz", psw[1:0], 2'b11);

    // Response back-pressure with another requester waiting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(3, 8'hF0, 8'h0F, OP_OR);
    wait_ready(3);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    drive(0, 8'h3C, 8'h0F, OP_AND);
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_rsp", {rsp_valid, rsp_id, rsp_psw, rsp_result},
            {1'b1, 2'd3, 4'b0100, 8'hFF});
      check("t4_hold_ready", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_idle_valid", rsp_valid, 0);
    check("t4_idle_ready", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_rsp();
    check("t4_and_rsp", {rsp_id, rsp_psw, rsp_result},
          {2'd0, 4'b0000, 8'h0C});

    // Reset while the ALU op is executing.
    @(posedge clk); #1;
    drive(1, 8'd9, 8'd3, OP_SUB);
    wait_ready(1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("t5_async_rsp", {rsp_valid, rsp_id, rsp_psw, rsp_result}, 0);
    check("t5_async_alu", {alu_a, alu_b, alu_sel}, 0);
    check("t5_async_ready", req_ready, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_no_stale", rsp_valid, 0);
    end

    // All requesters busy: strict rotation from a fresh pointer.
    @(posedge clk); #1;
    drive(0, 8'd10, 8'd20, OP_ADD);
    drive(1, 8'd3, 8'd7, OP_SUB);
    drive(2, 8'hAA, 8'h55, OP_XOR);
    drive(3, 8'h81, 8'h00, OP_SHL);
    collect(5);
    @(posedge clk); #1 req_valid = '0;
    check("t3_order0", ord[0], 0);
    check("t3_order1", ord[1], 1);
    check("t3_order2", ord[2], 2);
    check("t3_order3", ord[3], 3);
    check("t3_order4", ord[4], 0);
    repeat (4) @(negedge clk);

`ifdef ALU_ARB_LOCK_EN
    @(posedge clk); #1;
    drive(0, 8'd1, 8'd1, OP_ADD);
    drive(1, 8'd2, 8'd1, OP_SUB);
    drive(2, 8'd4, 8'd0, OP_NOT);
    req_lock[1] = 1'b1;
    collect(5);
    @(posedge clk); #1;
    req_valid = '0;
    req_lock = '0;
    check("t6_lock0", ord[0], 1);
    check("t6_lock1", ord[1], 1);
    check("t6_lock2", ord[2], 1);
    check("t6_lock3", ord[3], 1);
    check("t6_after", ord[4], 2);
    repeat (4) @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
